// File: rtl/cpc_romsel.sv
// cpc_romsel: upper/lower ROM paging for NUM_DEVICES 32 KB EEPROMs,
// DIP-selected base, lower-ROM replacement, unlock-protected writes.
module cpc_romsel #(
    parameter int         NUM_DEVICES = 3,
    parameter logic [7:0] CTRL_PORT   = 8'hDE,
    parameter int         TIMEOUT_W   = 24
) (
    input  logic                   CLK,
    input  logic                   RESET_B,
    input  logic [15:0]            A,
    input  logic [7:0]             D,
    input  logic                   MREQ_B,
    input  logic                   IOREQ_B,
    input  logic                   RD_B,
    input  logic                   WR_B,
    input  logic                   ROMEN_B,
    input  logic [7:0]             dip,
    output logic [NUM_DEVICES-1:0] rom_cs_b,
    output logic [NUM_DEVICES-1:0] rom_we_b,
    output logic                   rom_oe_b,
    output logic                   rom_a14,
    output logic                   romdis,
    output logic                   wr_unlocked
);

    typedef enum logic [1:0] {
        LOCKED,
        KEY1,
        KEY2,
        UNLOCKED
    } state_t;

    state_t               state, state_n;
    logic                 iowr, iowr_s, iowr_p, iowr_edge;
    logic                 ctrl_edge;
    logic [7:0]           cap_a, cap_d, romnum;
    logic [TIMEOUT_W-1:0] timer;
    logic [8:0]           base, off, dev;
    logic                 in_range, hit, unlocked, mem_wr;
    logic                 up_rd, lo_rd, up_wr, lo_wr;
    logic                 we_any, cs_any;
    logic                 unused_addr;

    assign iowr = ~IOREQ_B & ~WR_B;
    assign unused_addr = ^A[7:0];

    // Sample the IO write strobe; latch port and data on its first active sample
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            iowr_s <= 1'b0;
            iowr_p <= 1'b0;
            cap_a  <= '0;
            cap_d  <= '0;
        end else begin
            iowr_s <= iowr;
            iowr_p <= iowr_s;
            if (iowr && !iowr_s) begin
                cap_a <= A[15:8];
                cap_d <= D;
            end
        end
    end

    assign iowr_edge = iowr_s & ~iowr_p;
    assign ctrl_edge = iowr_edge && (cap_a == CTRL_PORT);

    // ROM select register follows the CPC partial decode (A13 low)
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            romnum <= '0;
        end else if (iowr_edge && !cap_a[5]) begin
            romnum <= cap_d;
        end
    end

    // ROM numbers past 255 do not exist, so 9-bit math avoids wrap
    assign base     = {1'b0, dip[6:0], 1'b0};
    assign off      = {1'b0, romnum} - base;
    assign dev      = off >> 1;
    assign in_range = ({1'b0, romnum} >= base)
                   && (off < 9'(2 * NUM_DEVICES));
    assign hit      = in_range && !(dip[7] && off == 9'd0);

    assign unlocked = (state == UNLOCKED);
    assign mem_wr   = unlocked & ~MREQ_B & ~WR_B;
    assign up_rd    = ~ROMEN_B & A[15] & A[14] & hit;
    assign lo_rd    = dip[7] & ~ROMEN_B & ~A[15] & ~A[14];
    assign up_wr    = mem_wr & A[15] & A[14] & hit;
    assign lo_wr    = mem_wr & dip[7] & ~A[15] & ~A[14];
    assign we_any   = up_wr | lo_wr;
    assign cs_any   = up_rd | lo_rd | we_any;

    // Unlock state register
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state <= LOCKED;
        end else begin
            state <= state_n;
        end
    end

    // Key sequence and inactivity relock
    always_comb begin
        state_n = state;
        if (ctrl_edge) begin
            unique case (state)
                LOCKED:   if (cap_d == 8'h55) state_n = KEY1;
                KEY1:     state_n = (cap_d == 8'hAA) ? KEY2 : LOCKED;
                KEY2:     state_n = (cap_d == 8'hC3) ? UNLOCKED : LOCKED;
                UNLOCKED: if (cap_d == 8'h00) state_n = LOCKED;
                default:  state_n = LOCKED;
            endcase
        end
        if (unlocked && !we_any && (&timer)) begin
            state_n = LOCKED;
        end
    end

    // Inactivity timer; held at zero outside write mode, ROM writes restart it
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            timer <= '0;
        end else if (!unlocked || we_any) begin
            timer <= '0;
        end else begin
            timer <= timer + TIMEOUT_W'(1);
        end
    end

    // EEPROM strobes, all forced inactive while reset is held
    always_comb begin
        rom_cs_b    = '1;
        rom_we_b    = '1;
        rom_oe_b    = 1'b1;
        rom_a14     = 1'b0;
        romdis      = 1'b0;
        wr_unlocked = 1'b0;
        if (RESET_B) begin
            for (int i = 0; i < NUM_DEVICES; i++) begin
                if ((up_rd || up_wr) && dev == 9'(i)) rom_cs_b[i] = 1'b0;
                if (up_wr && dev == 9'(i)) rom_we_b[i] = 1'b0;
            end
            if (lo_rd || lo_wr) rom_cs_b[0] = 1'b0;
            if (lo_wr) rom_we_b[0] = 1'b0;
            rom_a14     = (up_rd | up_wr) & off[0];
            romdis      = up_rd | lo_rd;
            rom_oe_b    = we_any ? 1'b1 : (cs_any ? RD_B : 1'b1);
            wr_unlocked = unlocked;
        end
    end

endmodule

// File: tb/tb_cpc_romsel.sv
// tb_cpc_romsel: scoreboarded random and directed stimulus for cpc_romsel
// against a spec-level model of paging and the unlock sequence.
module tb_cpc_romsel;

    localparam int ND   = 3;
    localparam int TW   = 4;
    localparam int TMAX = (1 << TW) - 1;

    logic          CLK     = 1'b0;
    logic          RESET_B = 1'b0;
    logic [15:0]   A       = '0;
    logic [7:0]    D       = '0;
    logic          MREQ_B  = 1'b1;
    logic          IOREQ_B = 1'b1;
    logic          RD_B    = 1'b1;
    logic          WR_B    = 1'b1;
    logic          ROMEN_B = 1'b1;
    logic [7:0]    dip     = 8'h03;
    logic [ND-1:0] rom_cs_b, rom_we_b;
    logic          rom_oe_b, rom_a14, romdis, wr_unlocked;

    cpc_romsel #(
        .NUM_DEVICES(ND),
        .CTRL_PORT  (8'hDE),
        .TIMEOUT_W  (TW)
    ) dut (
        .CLK        (CLK),
        .RESET_B    (RESET_B),
        .A          (A),
        .D          (D),
        .MREQ_B     (MREQ_B),
        .IOREQ_B    (IOREQ_B),
        .RD_B       (RD_B),
        .WR_B       (WR_B),
        .ROMEN_B    (ROMEN_B),
        .dip        (dip),
        .rom_cs_b   (rom_cs_b),
        .rom_we_b   (rom_we_b),
        .rom_oe_b   (rom_oe_b),
        .rom_a14    (rom_a14),
        .romdis     (romdis),
        .wr_unlocked(wr_unlocked)
    );

    always #5 CLK = ~CLK;

    localparam logic [9:0] IDLE_OUT = 10'b111_111_1_0_0_0;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [9:0] exp_q[$];
    string      tag_q[$];
    string      cur_tag = "init";

    // model: ROM number, keys matched so far (3 = unlocked), idle timer
    int         m_romnum = 0;
    int         m_keys   = 0;
    int         m_timer  = 0;
    bit         m_prev   = 0;
    bit         m_pend   = 0;
    bit         m_we     = 0;
    logic [7:0] m_pa     = '0;
    logic [7:0] m_pd     = '0;

    function automatic logic [7:0] key_of(int i);
        case (i)
            0:       return 8'h55;
            1:       return 8'hAA;
            default: return 8'hC3;
        endcase
    endfunction

    function automatic logic [9:0] observe();
        return {rom_cs_b, rom_we_b, rom_oe_b, rom_a14, romdis, wr_unlocked};
    endfunction

    task automatic compare(string name, logic [9:0] act, logic [9:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got cs=%b we=%b oe=%b a14=%b romdis=%b unl=%b, expected cs=%b we=%b oe=%b a14=%b romdis=%b unl=%b",
                     name, act[9:7], act[6:4], act[3], act[2], act[1], act[0],
                     exp[9:7], exp[6:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // monitor: pops one expectation per cycle, mid-cycle
    always @(negedge CLK) begin
        logic [9:0] e;
        string      t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            compare(t, observe(), e);
        end
    end

    task automatic expect_now(input logic [15:0] a, input logic [7:0] d,
                              input logic mreq, input logic ioreq,
                              input logic rd, input logic wr,
                              input logic romen);
        logic [2:0] cs, we;
        logic       oe, a14, rdis, unl;
        int         base, off;
        bit         hit, up, lo, rdu, rdl, wru, wrl;
        A = a; D = d; MREQ_B = mreq; IOREQ_B = ioreq;
        RD_B = rd; WR_B = wr; ROMEN_B = romen;
        if (!RESET_B) begin
            m_we = 0;
            exp_q.push_back(IDLE_OUT);
        end else begin
            base = int'(dip[6:0]) * 2;
            off  = m_romnum - base;
            hit  = (off >= 0) && (off < 2 * ND) && !(dip[7] && off == 0);
            up   = (a[15:14] == 2'b11);
            lo   = (a[15:14] == 2'b00);
            unl  = (m_keys == 3);
            rdu  = !romen && up && hit;
            rdl  = dip[7] && !romen && lo;
            wru  = unl && !mreq && !wr && up && hit;
            wrl  = unl && !mreq && !wr && dip[7] && lo;
            cs = 3'b111;
            we = 3'b111;
            if (rdu || wru) cs[2'(off / 2)] = 1'b0;
            if (wru) we[2'(off / 2)] = 1'b0;
            if (rdl || wrl) cs[0] = 1'b0;
            if (wrl) we[0] = 1'b0;
            a14  = (rdu || wru) && (off % 2 == 1);
            rdis = rdu || rdl;
            oe   = (wru || wrl) ? 1'b1 : ((cs != 3'b111) ? rd : 1'b1);
            m_we = wru || wrl;
            exp_q.push_back({cs, we, oe, a14, rdis, unl});
        end
        tag_q.push_back(cur_tag);
    endtask

    // model of what the clock edge ending this cycle does
    task automatic model_edge();
        bit relock, cur;
        int was;
        if (!RESET_B) begin
            m_romnum = 0; m_keys = 0; m_timer = 0;
            m_prev = 0; m_pend = 0;
        end else begin
            relock = (m_keys == 3) && !m_we && (m_timer == TMAX);
            was    = m_keys;
            m_timer = ((m_keys == 3) && !m_we) ? (m_timer + 1) % (TMAX + 1) : 0;
            if (m_pend) begin
                if (!m_pa[5]) m_romnum = int'(m_pd);
                if (m_pa == 8'hDE) begin
                    if (m_keys == 3) begin
                        if (m_pd == 8'h00) m_keys = 0;
                    end else if (m_pd == key_of(m_keys)) begin
                        m_keys++;
                    end else begin
                        m_keys = 0;
                    end
                end
                m_pend = 0;
            end
            if (was != 3 && m_keys == 3) m_timer = 0;
            if (relock) m_keys = 0;
            cur = !IOREQ_B && !WR_B;
            if (cur && !m_prev) begin
                m_pend = 1; m_pa = A[15:8]; m_pd = D;
            end
            m_prev = cur;
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [7:0] d,
                         input logic mreq, input logic ioreq,
                         input logic rd, input logic wr, input logic romen);
        expect_now(a, d, mreq, ioreq, rd, wr, romen);
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(16'h0000, 8'h00, 1, 1, 1, 1, 1);
    endtask

    task automatic io_out(input logic [7:0] port, input logic [7:0] d,
                          input int len);
        logic [15:0] a;
        a = {port, 8'($urandom)};
        for (int i = 0; i < len; i++) drive(a, d, 1, 0, 1, 0, 1);
        idle(1);
    endtask

    task automatic mem_read(input logic [15:0] a, input logic romen);
        drive(a, 8'($urandom), 0, 1, 0, 1, romen);
        drive(a, 8'($urandom), 0, 1, 1, 1, romen);
    endtask

    task automatic mem_write(input logic [15:0] a, input logic [7:0] d);
        drive(a, d, 0, 1, 1, 0, 1);
    endtask

    task automatic unlock();
        io_out(8'hDE, 8'h55, 3);
        io_out(8'hDE, 8'hAA, 3);
        io_out(8'hDE, 8'hC3, 3);
    endtask

    function automatic logic [7:0] pick_dip();
        case ($urandom_range(0, 5))
            0:       return 8'h03;
            1:       return 8'h83;
            2:       return 8'hFF;
            3:       return 8'h00;
            4:       return 8'h80;
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic logic [7:0] pick_key();
        case ($urandom_range(0, 4))
            0:       return 8'h55;
            1:       return 8'hAA;
            2:       return 8'hC3;
            3:       return 8'h00;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        @(posedge CLK);
        #1;
        cur_tag = "reset_hold";
        drive(16'hC000, 8'h07, 0, 1, 0, 1, 0);
        drive(16'hDF07, 8'h07, 1, 0, 1, 0, 1);
        RESET_B = 1'b1;
        cur_tag = "after_reset";
        idle(1);
        mem_read(16'hC000, 0);

        dip = 8'h03;
        cur_tag = "base6_sel07";
        io_out(8'hDF, 8'h07, 3);
        mem_read(16'hC000, 0);
        cur_tag = "base6_sel0C";
        io_out(8'hDF, 8'h0C, 3);
        mem_read(16'hC000, 0);
        cur_tag = "base6_sel05";
        io_out(8'hDF, 8'h05, 3);
        mem_read(16'hC000, 0);
        cur_tag = "base6_sel0B";
        io_out(8'hDF, 8'h0B, 3);
        mem_read(16'hFFFF, 0);

        dip = 8'hFF;
        cur_tag = "base254_selFF";
        io_out(8'hDF, 8'hFF, 3);
        mem_read(16'hC000, 0);
        cur_tag = "base254_nowrap";
        io_out(8'hDF, 8'h00, 3);
        mem_read(16'hC000, 0);

        dip = 8'h80;
        cur_tag = "lower_rom";
        mem_read(16'h0000, 0);
        cur_tag = "lower_excl_upper";
        mem_read(16'hC000, 0);

        dip = 8'h03;
        cur_tag = "unlock_write";
        unlock();
        io_out(8'hDF, 8'h09, 3);
        mem_write(16'hC000, 8'hA5);
        cur_tag = "timeout_relock";
        idle(20);
        mem_write(16'hC000, 8'hA5);
        cur_tag = "bad_key";
        io_out(8'hDE, 8'h55, 3);
        io_out(8'hDE, 8'h12, 3);
        io_out(8'hDE, 8'hC3, 3);
        io_out(8'hDF, 8'h09, 3);
        mem_write(16'hC000, 8'hA5);

        cur_tag = "write_holds";
        unlock();
        io_out(8'hDF, 8'h09, 3);
        idle(8);
        mem_write(16'hC000, 8'h11);
        idle(13);
        mem_write(16'hC000, 8'h22);
        idle(20);

        cur_tag = "relock_by_key";
        unlock();
        io_out(8'hDE, 8'h00, 3);
        io_out(8'hDF, 8'h09, 3);
        mem_write(16'hC000, 8'h33);

        cur_tag = "reset_mid_write";
        unlock();
        io_out(8'hDF, 8'h09, 3);
        expect_now(16'hC000, 8'h5A, 0, 1, 1, 0, 1);
        @(negedge CLK);
        #2;
        RESET_B = 1'b0;
        #1;
        compare("reset_async", observe(), IDLE_OUT);
        cur_tag = "in_reset";
        expect_now(16'hC000, 8'h5A, 0, 1, 1, 0, 1);
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        #1;
        A = '0; MREQ_B = 1; IOREQ_B = 1; RD_B = 1; WR_B = 1; ROMEN_B = 1;
        RESET_B = 1'b1;
        @(posedge CLK);
        m_we = 0;
        model_edge();
        #1;

        cur_tag = "random";
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0: begin dip = pick_dip(); idle(1); end
                1, 2: io_out(8'hDF,
                             8'(int'(dip[6:0]) * 2 + $urandom_range(0, 7) - 1),
                             $urandom_range(1, 3));
                3: io_out(8'hDE, pick_key(), $urandom_range(1, 3));
                4: unlock();
                5: io_out(8'($urandom), 8'($urandom), $urandom_range(1, 3));
                6, 7: mem_read(16'($urandom), 1'($urandom_range(0, 1)));
                8: mem_write(16'($urandom), 8'($urandom));
                default: idle($urandom_range(1, 5));
            endcase
        end

        idle(1);
        @(negedge CLK);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0",
                     exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
